// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MDU_MADD_EN macro adds madd/maddu (ops 4/5) with a 64-bit accumulator.
//
// state  | meaning
// S_IDLE | no operation in flight; mthi/mtlo accepted when start is low
// S_RUN  | counter running down; HI/LO written on the 1->0 step
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  op_e           op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic          op_legal;
  logic          op_is_div;

  always_comb begin
    op_legal  = 1'b0;
    op_is_div = 1'b0;
    case (op)
      3'd0, 3'd1: op_legal = 1'b1;
      3'd2, 3'd3: begin
        op_legal  = 1'b1;
        op_is_div = 1'b1;
      end
`ifdef MDU_MADD_EN
      3'd4, 3'd5: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Products are taken mod 2^64, so the signed form is just a sign-extended unsigned multiply.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
  end

  // Signed divide works on magnitudes so that 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic        div_zero;
  logic [31:0] b_safe;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  always_comb begin
    div_zero = (b_q == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_q;
    a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag    = b_q[31] ? (~b_q + 32'd1) : b_safe;
    q_mag    = a_mag / b_mag;
    r_mag    = a_mag % b_mag;
    q_s      = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s      = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    q_u      = a_q / b_safe;
    r_u      = a_q % b_safe;
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc;

  always_comb begin
    acc = {hi, lo} + ((op_q == OP_MADD) ? prod_s : prod_u);
  end
`endif

  logic        res_we;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_we = 1'b1;
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_we = ~div_zero;
        res_hi = r_s;
        res_lo = q_s;
      end
      OP_DIVU: begin
        res_we = ~div_zero;
        res_hi = r_u;
        res_lo = q_u;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: {res_hi, res_lo} = acc;
`endif
      default: res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_legal) begin
              op_q  <= op_e'(op);
              a_q   <= a;
              b_q   <= b;
              cnt   <= op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against
// a 64-bit arithmetic reference model. Honours MDU_MADD_EN the same way as the design.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_hl     = 64'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return o <= 3'd5;
`else
    return o <= 3'd3;
`endif
  endfunction

  function automatic int latency(input logic [2:0] o);
    return (o == 3'd2 || o == 3'd3) ? DIV_N : MULT_N;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] hl);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return hl;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return hl;
        return {x % y, x / y};
      end
      3'd4: return hl + sx * sy;
      3'd5: return hl + ux * uy;
      default: return hl;
    endcase
  endfunction

  task automatic wait_done(input int exp_n, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, n, exp_n);
    check({tag, "_hi"}, hi, m_hl[63:32]);
    check({tag, "_lo"}, lo, m_hl[31:0]);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic with_mt, input string tag);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    hi_we = with_mt; lo_we = with_mt;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
    if (is_legal(o)) begin
      m_hl = model(o, x, y, m_hl);
      wait_done(latency(o), tag);
    end else begin
      repeat (2) @(negedge clk);
      check({tag, "_rsv_busy"}, busy, 0);
      check({tag, "_rsv_hi"}, hi, m_hl[63:32]);
      check({tag, "_rsv_lo"}, lo, m_hl[31:0]);
    end
  endtask

  task automatic do_mt(input logic hw, input logic lw, input logic [31:0] x, input string tag);
    @(negedge clk);
    hi_we = hw; lo_we = lw; a = x;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hl[63:32] = x;
    if (lw) m_hl[31:0]  = x;
    @(negedge clk);
    check({tag, "_hi"}, hi, m_hl[63:32]);
    check({tag, "_lo"}, lo, m_hl[31:0]);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    do_mt(1'b1, 1'b1, 32'h11, "mt_both");
    do_mt(1'b0, 1'b1, 32'h22, "mtlo_22");
    run_op(3'd3, 32'd7, 32'd0, 1'b0, "divu_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    do_mt(1'b1, 1'b0, 32'h1234, "mthi");
    do_mt(1'b0, 1'b1, 32'h5678, "mtlo");
    run_op(3'd0, 32'd9, 32'd7, 1'b1, "mult_mt_drop");

    // second start during a divide must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    m_hl = model(3'd2, 32'd100, 32'd7, m_hl);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(DIV_N - 3, "div_restart");

    // reset mid-operation discards the result
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hl = 64'd0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    repeat (12) @(negedge clk);
    check("abort_late_hi", hi, 0);
    check("abort_late_lo", lo, 0);

    do_mt(1'b1, 1'b1, 32'hFFFF_FFFF, "madd_pre");
    do_mt(1'b1, 1'b0, 32'd0, "madd_pre_hi");
    run_op(3'd5, 32'd1, 32'd1, 1'b0, "maddu_carry");
    run_op(3'd4, 32'hFFFF_FFFD, 32'd4, 1'b0, "madd_neg");
    run_op(3'd6, 32'd3, 32'd3, 1'b0, "rsv6");

    for (int i = 0; i < 80; i++) begin
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = $urandom_range(1, 20);
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      if ($urandom_range(0, 9) < 2) begin
        do_mt(1'($urandom), 1'($urandom), rx, "rand_mt");
      end else begin
        ro = 3'($urandom_range(0, 7));
        run_op(ro, rx, ry, 1'($urandom_range(0, 3) == 0), "rand_op");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
